seven_seg_scan_decoder: RTL and testbench
=========================================

SEVEN_SEG_SCAN_DECODER -- requirements
Module: seven_seg_scan_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 16 -- consecutive identical (seg, an) samples required before capture; legal range 2..1023.
REQ-002 clk  input  1  -- sole clock; all state updates on rising edge.
REQ-003 rst  input  1  -- reset, synchronous, active-high.
REQ-004 seg  input  7  -- observed segment bus, active-low, bit order {g,f,e,d,c,b,a}.
REQ-005 an  input  4  -- observed anode selects, active-low, bit i selects digit position i.
REQ-006 digits  output  16  -- recovered BCD digits, position i in bits [4i+3:4i].
REQ-007 digit_valid  output  4  -- bit i high when position i holds a decoded numeral.
REQ-008 frame_done  output  1  -- one-cycle pulse when all four positions have been captured since the previous pulse.
REQ-009 bad_pattern  output  1  -- one-cycle pulse on capture of an undecodable segment pattern.

Function
REQ-010 The anode input shall be valid only when exactly one bit of an is low; any other value shall be treated as no active position.
REQ-011 The block shall implement states IDLE (no valid anode), TRACK (counting stability) and HELD (captured, awaiting change).
REQ-012 In any state, an invalid anode shall force IDLE and clear the stability counter on that edge.
REQ-013 A valid (seg, an) pair differing from the previous edge's pair shall enter TRACK with the counter at 1.
REQ-014 In TRACK, an unchanged pair shall increment the counter; when the counter reaches STABLE_CYCLES the block shall capture and enter HELD on that same edge.
REQ-015 A pair first sampled at edge k and held unchanged shall have its capture visible on outputs immediately after edge k+STABLE_CYCLES-1.
REQ-016 A pair change on the edge that would otherwise capture shall suppress capture and restart TRACK at 1.
REQ-017 In HELD, an unchanged pair shall not re-capture; a changed valid pair shall enter TRACK at 1.
REQ-018 Capture shall decode seg: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-019 A decoded numeral shall write digits[position] and set digit_valid[position].
REQ-020 Blank pattern 1111111 shall clear digit_valid[position], leave digits[position] unchanged, no bad_pattern.
REQ-021 Any other pattern shall clear digit_valid[position], leave digits[position] unchanged and pulse bad_pattern.
REQ-022 Every capture (numeral, blank or bad) shall set that position's bit in an internal captured mask.
REQ-023 When the mask becomes 4'b1111, frame_done shall pulse on the same edge as that capture and the mask shall clear.
REQ-024 The stability counter shall saturate and never wrap.

Reset
REQ-025 On rst high: state IDLE, counter 0, captured mask 0, digits 16'h0000, digit_valid 4'b0000, frame_done 0, bad_pattern 0.
REQ-026 rst shall override all simultaneous events, including an in-progress capture.

Configuration
REQ-027 With SEVEN_SEG_DP_EN defined, the block shall add input dp (1, active-low) and output dp_on (4); dp becomes part of the compared pair and capture writes dp_on[position] = ~dp.
REQ-028 Without SEVEN_SEG_DP_EN, neither port shall exist and stability shall compare seg and an only.

Structure
REQ-029 Package seven_seg_pkg shall hold the ten numeral patterns, the blank pattern constant and the IDLE/TRACK/HELD state type.
REQ-030 Sub-module seg_pattern_decode shall be combinational: 7-bit pattern in; 4-bit BCD, numeral flag, blank flag out.

Verification
REQ-031 STABLE_CYCLES=4, an=1110, seg=0100100 held 4 edges -> digits[3:0]=2, digit_valid=0001 after 4th edge; none after 3rd.
REQ-032 Pattern 1111001 held 3 edges then changed to 0110000 on 4th -> no capture of 1; 3 visible after 3 more edges.
REQ-033 Positions 0..3 each held 4 edges with 0,1,2,3 -> digits=16'h3210, digit_valid=1111, one frame_done pulse coincident with position 3 capture.
REQ-034 an=1100 or 1111 for 10 edges -> no captures, counter held 0; seg=1111111 on position 1 -> digit_valid[1]=0, no bad_pattern; seg=0101010 -> one bad_pattern pulse.
REQ-035 rst asserted on edge where capture would occur -> outputs all zero, no capture, no frame_done.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scan decoder: active-low numeral/blank patterns,
// scan FSM state type and anode one-cold decode helper.
package seven_seg_pkg;

   // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam int CNT_W = 10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TRACK = 2'd1,
      HELD  = 2'd2
   } scan_state_t;

   typedef struct packed {
      logic       ok;
      logic [1:0] pos;
   } an_sel_t;

   // Only a single low anode bit names a position; anything else means no position
   function automatic an_sel_t an_decode(input logic [3:0] an);
      an_sel_t sel;
      sel.ok  = 1'b1;
      sel.pos = 2'd0;
      case (an)
         4'b1110: sel.pos = 2'd0;
         4'b1101: sel.pos = 2'd1;
         4'b1011: sel.pos = 2'd2;
         4'b0111: sel.pos = 2'd3;
         default: sel.ok  = 1'b0;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational decode of an active-low 7-segment pattern to BCD plus numeral/blank flags.
// Zero latency; no flow control.
module seg_pattern_decode
   import seven_seg_pkg::*;
(
   input  logic [6:0] pattern,
   output logic [3:0] bcd,
   output logic       is_numeral,
   output logic       is_blank
);

   always_comb begin
      bcd        = 4'd0;
      is_numeral = 1'b1;
      is_blank   = 1'b0;
      case (pattern)
         SEG_0:     bcd = 4'd0;
         SEG_1:     bcd = 4'd1;
         SEG_2:     bcd = 4'd2;
         SEG_3:     bcd = 4'd3;
         SEG_4:     bcd = 4'd4;
         SEG_5:     bcd = 4'd5;
         SEG_6:     bcd = 4'd6;
         SEG_7:     bcd = 4'd7;
         SEG_8:     bcd = 4'd8;
         SEG_9:     bcd = 4'd9;
         SEG_BLANK: begin
            is_numeral = 1'b0;
            is_blank   = 1'b1;
         end
         default:   is_numeral = 1'b0;
      endcase
   end

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// Recovers BCD digits from a multiplexed 7-segment scan once (seg, an) is stable STABLE_CYCLES edges;
// capture visible after edge k+STABLE_CYCLES-1, no backpressure. SEVEN_SEG_DP_EN adds dp/dp_on.
module seven_seg_scan_decoder
   import seven_seg_pkg::*;
#(
   parameter int STABLE_CYCLES = 16
)(
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  seg,
   input  logic [3:0]  an,
`ifdef SEVEN_SEG_DP_EN
   input  logic        dp,
   output logic [3:0]  dp_on,
`endif
   output logic [15:0] digits,
   output logic [3:0]  digit_valid,
   output logic        frame_done,
   output logic        bad_pattern
);

   localparam logic [CNT_W-1:0] STABLE_CNT = CNT_W'(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

   scan_state_t      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic [6:0]       prev_seg_q;
   logic [3:0]       prev_an_q;
   logic [3:0]       mask_q, mask_d, mask_set;
   logic [15:0]      digits_d;
   logic [3:0]       valid_d;
   logic             frame_d;
   logic             bad_d;
   logic             capture;
   logic             pair_changed;
   an_sel_t          sel;

   logic [3:0]       dec_bcd;
   logic             dec_numeral;
   logic             dec_blank;

`ifdef SEVEN_SEG_DP_EN
   logic             prev_dp_q;
   logic [3:0]       dp_on_d;
`endif

   seg_pattern_decode u_decode (
      .pattern    (seg),
      .bcd        (dec_bcd),
      .is_numeral (dec_numeral),
      .is_blank   (dec_blank)
   );

   assign sel = an_decode(an);

`ifdef SEVEN_SEG_DP_EN
   assign pair_changed = (seg != prev_seg_q) || (an != prev_an_q) || (dp != prev_dp_q);
`else
   assign pair_changed = (seg != prev_seg_q) || (an != prev_an_q);
`endif

   assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

   // Next-state: stability tracking and capture strobe
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      capture = 1'b0;
      if (!sel.ok) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = TRACK;
               cnt_d   = CNT_W'(1);
            end
            TRACK: begin
               if (pair_changed) begin
                  cnt_d = CNT_W'(1);
               end else begin
                  cnt_d = cnt_inc;
                  if (cnt_inc == STABLE_CNT) begin
                     capture = 1'b1;
                     state_d = HELD;
                  end
               end
            end
            HELD: begin
               if (pair_changed) begin
                  state_d = TRACK;
                  cnt_d   = CNT_W'(1);
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Capture datapath: blank and bad patterns both invalidate the position but keep its old digit
   always_comb begin
      digits_d = digits;
      valid_d  = digit_valid;
      mask_d   = mask_q;
      frame_d  = 1'b0;
      bad_d    = 1'b0;
      mask_set = mask_q | (4'b0001 << sel.pos);
`ifdef SEVEN_SEG_DP_EN
      dp_on_d  = dp_on;
`endif
      if (capture) begin
         if (dec_numeral) begin
            digits_d[{sel.pos, 2'b00} +: 4] = dec_bcd;
            valid_d[sel.pos]                = 1'b1;
         end else begin
            valid_d[sel.pos] = 1'b0;
            bad_d            = !dec_blank;
         end
`ifdef SEVEN_SEG_DP_EN
         dp_on_d[sel.pos] = ~dp;
`endif
         if (mask_set == 4'b1111) begin
            frame_d = 1'b1;
            mask_d  = 4'b0000;
         end else begin
            mask_d  = mask_set;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         prev_seg_q  <= SEG_BLANK;
         prev_an_q   <= 4'b1111;
         mask_q      <= 4'b0000;
         digits      <= 16'h0000;
         digit_valid <= 4'b0000;
         frame_done  <= 1'b0;
         bad_pattern <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         prev_seg_q  <= seg;
         prev_an_q   <= an;
         mask_q      <= mask_d;
         digits      <= digits_d;
         digit_valid <= valid_d;
         frame_done  <= frame_d;
         bad_pattern <= bad_d;
      end
   end

`ifdef SEVEN_SEG_DP_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_dp_q <= 1'b1;
         dp_on     <= 4'b0000;
      end else begin
         prev_dp_q <= dp;
         dp_on     <= dp_on_d;
      end
   end
`endif

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Directed-vector bench for seven_seg_scan_decoder at STABLE_CYCLES=4.
module tb_seven_seg_scan_decoder;

   localparam logic [6:0] P0  = 7'b1000000;
   localparam logic [6:0] P1  = 7'b1111001;
   localparam logic [6:0] P2  = 7'b0100100;
   localparam logic [6:0] P3  = 7'b0110000;
   localparam logic [6:0] P9  = 7'b0010000;
   localparam logic [6:0] PBL = 7'b1111111;
   localparam logic [6:0] PBD = 7'b0101010;

   logic        clk;
   logic        rst;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic [15:0] digits;
   logic [3:0]  digit_valid;
   logic        frame_done;
   logic        bad_pattern;
`ifdef SEVEN_SEG_DP_EN
   logic        dp;
   logic [3:0]  dp_on;
`endif

   int n_vec = 0;
   int n_err = 0;
   int fd_cnt = 0;
   int bp_cnt = 0;

   seven_seg_scan_decoder #(.STABLE_CYCLES(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .seg         (seg),
      .an          (an),
`ifdef SEVEN_SEG_DP_EN
      .dp          (dp),
      .dp_on       (dp_on),
`endif
      .digits      (digits),
      .digit_valid (digit_valid),
      .frame_done  (frame_done),
      .bad_pattern (bad_pattern)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One rising edge, then sample 1ns later and tally output pulses
   task automatic tick();
      @(posedge clk);
      #1;
      if (frame_done)  fd_cnt++;
      if (bad_pattern) bp_cnt++;
   endtask

   task automatic drive(input logic [6:0] s, input logic [3:0] a, input int n);
      seg = s;
      an  = a;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_digits"}, 32'(digits), 32'h0);
      chk({tag, "_valid"},  32'(digit_valid), 32'h0);
      chk({tag, "_frame"},  32'(frame_done), 32'h0);
      chk({tag, "_bad"},    32'(bad_pattern), 32'h0);
   endtask

   initial begin
`ifdef SEVEN_SEG_DP_EN
      dp = 1'b1;
`endif
      rst = 1'b1;
      seg = PBL;
      an  = 4'b1111;
      tick();
      tick();
      check_zero("reset");

      // Numeral 2 on position 0: not yet after 3 edges, captured on the 4th
      rst = 1'b0;
      drive(P2, 4'b1110, 3);
      chk("p0_early_valid", 32'(digit_valid), 32'h0);
      drive(P2, 4'b1110, 1);
      chk("p0_digit", 32'(digits[3:0]), 32'h2);
      chk("p0_valid", 32'(digit_valid), 32'h1);

      // 1 held 3 edges then replaced by 3: 1 never captured, 3 lands 3 edges after the change
      drive(P1, 4'b1110, 3);
      chk("glitch_keep2", 32'(digits[3:0]), 32'h2);
      drive(P3, 4'b1110, 3);
      chk("glitch_no1", 32'(digits[3:0]), 32'h2);
      drive(P3, 4'b1110, 1);
      chk("glitch_got3", 32'(digits[3:0]), 32'h3);
      chk("glitch_valid", 32'(digit_valid), 32'h1);

      // Full frame 0,1,2,3 from a clean reset
      rst = 1'b1;
      drive(PBL, 4'b1111, 1);
      check_zero("reset2");
      rst = 1'b0;
      fd_cnt = 0;
      drive(P0, 4'b1110, 4);
      drive(P1, 4'b1101, 4);
      drive(P2, 4'b1011, 4);
      chk("frame_before_p3", 32'(fd_cnt), 32'h0);
      drive(P3, 4'b0111, 4);
      chk("frame_pulse", 32'(frame_done), 32'h1);
      chk("frame_digits", 32'(digits), 32'h3210);
      chk("frame_valid", 32'(digit_valid), 32'hF);
      drive(P3, 4'b0111, 1);
      chk("frame_one_cycle", 32'(frame_done), 32'h0);
      drive(P3, 4'b0111, 6);
      chk("frame_count", 32'(fd_cnt), 32'h1);

      // Invalid anodes: nothing captured
      drive(P9, 4'b1100, 10);
      drive(P9, 4'b1111, 10);
      chk("inv_digits", 32'(digits), 32'h3210);
      chk("inv_valid", 32'(digit_valid), 32'hF);

      // Blank on position 1 clears its valid bit, keeps digit, no bad pulse
      bp_cnt = 0;
      drive(PBL, 4'b1101, 4);
      chk("blank_valid", 32'(digit_valid), 32'hD);
      chk("blank_digits", 32'(digits), 32'h3210);
      chk("blank_nobad", 32'(bp_cnt), 32'h0);

      // Undecodable pattern on position 2: single bad pulse, no re-capture while held
      drive(PBD, 4'b1011, 3);
      chk("bad_early", 32'(bad_pattern), 32'h0);
      drive(PBD, 4'b1011, 1);
      chk("bad_pulse", 32'(bad_pattern), 32'h1);
      chk("bad_valid", 32'(digit_valid), 32'h9);
      chk("bad_digits", 32'(digits), 32'h3210);
      drive(PBD, 4'b1011, 8);
      chk("bad_count", 32'(bp_cnt), 32'h1);
      chk("no_frame_partial", 32'(fd_cnt), 32'h1);

      // Reset on the would-be capture edge wins
      drive(P9, 4'b0111, 3);
      fd_cnt = 0;
      rst = 1'b1;
      drive(P9, 4'b0111, 1);
      check_zero("rst_capture");
      rst = 1'b0;
      drive(P9, 4'b0111, 3);
      chk("post_rst_early", 32'(digit_valid), 32'h0);
      drive(P9, 4'b0111, 1);
      chk("post_rst_digit", 32'(digits), 32'h9000);
      chk("post_rst_valid", 32'(digit_valid), 32'h8);
      chk("post_rst_noframe", 32'(fd_cnt), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
